// File: rtl/lcd_cmd_pkg.sv
// Shared definitions for the LCD SPI receiver: controller opcodes,
// command-FSM states and the CASET/RASET parameter byte count.
package lcd_cmd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int PARAM_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    CASET_P,
    RASET_P,
    RAMWR_HI,
    RAMWR_LO,
    SKIP
  } rx_state_t;

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronises the LCD link into
// the system clock domain and assembles MSB-first bytes tagged with dc.
module lcd_spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_cs,
  input  logic       lcd_sclk,
  input  logic       lcd_mosi,
  input  logic       lcd_dc,
  input  logic       lcd_rst,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       hw_rst
);

  logic [1:0] cs_sync;
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] dc_sync;
  logic [1:0] rst_sync;
  logic       sclk_d;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign hw_rst    = ~rst_sync[1];

  // Synchronisers keep running through a panel reset so its release is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync    <= 2'b11;
      sclk_sync  <= 2'b00;
      mosi_sync  <= 2'b00;
      dc_sync    <= 2'b00;
      rst_sync   <= 2'b11;
      sclk_d     <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[0], lcd_cs};
      sclk_sync  <= {sclk_sync[0], lcd_sclk};
      mosi_sync  <= {mosi_sync[0], lcd_mosi};
      dc_sync    <= {dc_sync[0], lcd_dc};
      rst_sync   <= {rst_sync[0], lcd_rst};
      sclk_d     <= sclk_sync[1];
      byte_valid <= 1'b0;
      if (hw_rst) begin
        shift     <= '0;
        bit_cnt   <= '0;
        byte_data <= '0;
        byte_dc   <= 1'b0;
      end else if (cs_sync[1]) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, mosi_sync[1]};
          byte_dc    <= dc_sync[1];
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI receive-side decoder: interprets CASET/RASET/RAMWR and emits
// RGB565 pixels with their window coordinates.
module lcd_spi_rx
  import lcd_cmd_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 240,
  parameter int CW    = 9
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          lcd_cs,
  input  logic          lcd_sclk,
  input  logic          lcd_mosi,
  input  logic          lcd_dc,
  input  logic          lcd_rst,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_dc,
  output logic          pix_valid,
  output logic [15:0]   pix_data,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_done,
  output logic          win_err
);

  localparam logic [15:0] H_LIM = 16'(H_RES);
  localparam logic [15:0] V_LIM = 16'(V_RES);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       hw_rst;

  lcd_spi_byte_rx u_byte_rx (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .lcd_cs     (lcd_cs),
    .lcd_sclk   (lcd_sclk),
    .lcd_mosi   (lcd_mosi),
    .lcd_dc     (lcd_dc),
    .lcd_rst    (lcd_rst),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .byte_dc    (rx_dc),
    .hw_rst     (hw_rst)
  );

  rx_state_t     state, state_n;
  logic [1:0]    pcnt, pcnt_n;
  logic [7:0]    prm0, prm0_n, prm1, prm1_n, prm2, prm2_n;
  logic [CW-1:0] xs, xs_n, xe, xe_n, ys, ys_n, ye, ye_n;
  logic [CW-1:0] cx, cx_n, cy, cy_n;
  logic [7:0]    hi, hi_n;
  logic          pv_q, pv_n, fd_q, fd_n, we_q, we_n;
  logic [15:0]   pd_q, pd_n;
  logic [CW-1:0] px_q, px_n, py_q, py_n;
  logic [15:0]   start_w, end_w, lim_w;

  // Pulses are masked while sys_rst is high so nothing escapes in the reset cycle.
  assign byte_valid = rx_valid & ~sys_rst;
  assign byte_data  = rx_data;
  assign byte_dc    = rx_dc;
  assign pix_valid  = pv_q & ~sys_rst;
  assign frame_done = fd_q & ~sys_rst;
  assign win_err    = we_q & ~sys_rst;
  assign pix_data   = pd_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || hw_rst) begin
      state <= IDLE;
      pcnt  <= '0;
      prm0  <= '0;
      prm1  <= '0;
      prm2  <= '0;
      xs    <= '0;
      xe    <= CW'(H_RES - 1);
      ys    <= '0;
      ye    <= CW'(V_RES - 1);
      cx    <= '0;
      cy    <= '0;
      hi    <= '0;
      pv_q  <= 1'b0;
      fd_q  <= 1'b0;
      we_q  <= 1'b0;
      pd_q  <= '0;
      px_q  <= '0;
      py_q  <= '0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      prm0  <= prm0_n;
      prm1  <= prm1_n;
      prm2  <= prm2_n;
      xs    <= xs_n;
      xe    <= xe_n;
      ys    <= ys_n;
      ye    <= ye_n;
      cx    <= cx_n;
      cy    <= cy_n;
      hi    <= hi_n;
      pv_q  <= pv_n;
      fd_q  <= fd_n;
      we_q  <= we_n;
      pd_q  <= pd_n;
      px_q  <= px_n;
      py_q  <= py_n;
    end
  end

  assign start_w = {prm0, prm1};
  assign end_w   = {prm2, rx_data};
  assign lim_w   = (state == CASET_P) ? H_LIM : V_LIM;

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    prm0_n  = prm0;
    prm1_n  = prm1;
    prm2_n  = prm2;
    xs_n    = xs;
    xe_n    = xe;
    ys_n    = ys;
    ye_n    = ye;
    cx_n    = cx;
    cy_n    = cy;
    hi_n    = hi;
    pv_n    = 1'b0;
    fd_n    = 1'b0;
    we_n    = 1'b0;
    pd_n    = pd_q;
    px_n    = px_q;
    py_n    = py_q;

    if (rx_valid) begin
      if (!rx_dc) begin
        pcnt_n = '0;
        case (rx_data)
          CMD_CASET: state_n = CASET_P;
          CMD_RASET: state_n = RASET_P;
          CMD_RAMWR: begin
            state_n = RAMWR_HI;
            cx_n    = xs;
            cy_n    = ys;
          end
          default:   state_n = SKIP;
        endcase
      end else begin
        case (state)
          CASET_P, RASET_P: begin
            if (pcnt != 2'(PARAM_BYTES - 1)) begin
              case (pcnt)
                2'd0:    prm0_n = rx_data;
                2'd1:    prm1_n = rx_data;
                default: prm2_n = rx_data;
              endcase
              pcnt_n = pcnt + 2'd1;
            end else begin
              state_n = IDLE;
              pcnt_n  = '0;
              // Range check on full 16-bit values; truncate only once accepted.
              if (start_w <= end_w && end_w < lim_w) begin
                if (state == CASET_P) begin
                  xs_n = CW'(start_w);
                  xe_n = CW'(end_w);
                end else begin
                  ys_n = CW'(start_w);
                  ye_n = CW'(end_w);
                end
              end else begin
                we_n = 1'b1;
              end
            end
          end
          RAMWR_HI: begin
            hi_n    = rx_data;
            state_n = RAMWR_LO;
          end
          RAMWR_LO: begin
            pv_n    = 1'b1;
            pd_n    = {hi, rx_data};
            px_n    = cx;
            py_n    = cy;
            state_n = RAMWR_HI;
            if (cx == xe) begin
              cx_n = xs;
              if (cy == ye) begin
                cy_n = ys;
                fd_n = 1'b1;
              end else begin
                cy_n = cy + CW'(1);
              end
            end else begin
              cx_n = cx + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- Receive-side model of the 4-wire LCD SPI link that spi_lcd drives (lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, lcd_rst).
- Oversamples the link in the sys_clk domain and assembles bytes tagged command or data.
- Decodes the controller command set CASET (0x2A), RASET (0x2B) and RAMWR (0x2C), and emits RGB565 pixels with their x/y coordinates.
- Used as a synthesizable loopback checker on-board and as the bench monitor for spi_lcd.

Parameters:
- H_RES, 240, panel width in pixels.
- V_RES, 240, panel height in pixels.
- CW, 9, coordinate width; must satisfy 2^CW >= max(H_RES, V_RES).

Ports:
- sys_clk  in  1  system clock (12 MHz nominal).
- sys_rst  in  1  synchronous, active-high reset.
- lcd_cs  in  1  chip select, active low, asynchronous to sys_clk.
- lcd_sclk  in  1  SPI clock, mode 0; frequency must be <= sys_clk/4.
- lcd_mosi  in  1  serial data, MSB first.
- lcd_dc  in  1  0 = command byte, 1 = data byte.
- lcd_rst  in  1  panel hardware reset, active low.
- byte_valid  out  1  one-cycle pulse when a byte completes.
- byte_data  out  8  received byte; valid when byte_valid is high.
- byte_dc  out  1  lcd_dc value sampled on bit 0 of the byte.
- pix_valid  out  1  one-cycle pulse when a pixel completes.
- pix_data  out  16  RGB565 pixel, high byte first on the wire.
- pix_x  out  CW  column of pix_data.
- pix_y  out  CW  row of pix_data.
- frame_done  out  1  pulse together with the last pixel of the window.
- win_err  out  1  pulse when a CASET or RASET parameter set is rejected.

Behaviour:
- Synchronisers:
  - lcd_cs, lcd_sclk, lcd_mosi, lcd_dc and lcd_rst each pass through a 2-FF synchroniser.
  - Rising edge of lcd_sclk is detected on the synchronised signal with a third register.
- Bit capture:
  - On each sclk rising edge while cs is low, shift in mosi and increment bit_cnt (3 bits).
  - On the 8th bit, assert byte_valid on the next sys_clk cycle.
  - Latency: 3–4 sys_clk cycles from the 8th sclk rising edge to byte_valid.
- cs high: clears bit_cnt and the shift register, so a partial byte is discarded. Command-FSM state is retained across cs toggles.
- Hardware reset: lcd_rst low (synchronised) has the same effect as sys_rst, except that no outputs pulse.
- Reset values:
  - All outputs 0.
  - Window registers: XS=0, XE=H_RES-1, YS=0, YE=V_RES-1.
  - Cursor: cx=XS, cy=YS.
  - FSM in IDLE.
- FSM states: IDLE, CASET_P, RASET_P, RAMWR_HI, RAMWR_LO, SKIP.
- Any byte with dc=0 is a command and is always taken, from every state:
  - 0x2A: enter CASET_P with param_cnt=0.
  - 0x2B: enter RASET_P with param_cnt=0.
  - 0x2C: enter RAMWR_HI and set cx=XS, cy=YS.
  - Any other opcode: enter SKIP.
  - A pending high pixel byte is dropped.
  - A partial parameter set is dropped without updating the window and without win_err.
- CASET_P / RASET_P:
  - Collect 4 data bytes: start[15:8], start[7:0], end[15:8], end[7:0].
  - After the 4th byte, check start <= end and end < H_RES (for CASET) or end < V_RES (for RASET).
  - If the check passes, commit start/end and go to IDLE.
  - If it fails, keep the old window, pulse win_err and go to IDLE.
  - Further data bytes in IDLE or SKIP are ignored.
- RAMWR_HI: store the data byte as pixel[15:8] and go to RAMWR_LO.
- RAMWR_LO:
  - Assert pix_valid with pix_data={hi,byte} and pix_x/pix_y = cx/cy, then go to RAMWR_HI.
  - Advance the cursor: cx++. If cx==XE, set cx=XS and cy++. If also cy==YE, set cy=YS and pulse frame_done on the same cycle as pix_valid.
  - The RAMWR stream continues indefinitely and wraps the window.
- Coordinate arithmetic is unsigned, CW bits. 16-bit parameters are truncated to CW bits only after the range check.
- sys_rst is sampled every cycle. It aborts any byte or pixel in progress; no pulse is emitted in the reset cycle or the cycle after.

Decomposition:
- Package lcd_cmd_pkg holds:
  - opcode constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C, CMD_SWRESET=8'h01;
  - the rx FSM state enum;
  - the parameter byte count (4).
- Sub-module lcd_spi_byte_rx contains the synchronisers, edge detect and shift register, and outputs byte_valid, byte_data and byte_dc.
- The top level holds the command FSM, window registers and cursor.

Test Plan:
- Reset, then command 0x2C followed by 4 data bytes 0xF8,0x00,0x07,0xE0 at sclk=sys_clk/4 -> two pix_valid pulses: (x0,y0)=16'hF800 and (x1,y0)=16'h07E0; byte_valid pulses 5 times with byte_dc 0,1,1,1,1.
- CASET 0,10,0,11; RASET 0,5,0,6; RAMWR with 4 pixels -> coordinates (10,5),(11,5),(10,6),(11,6); frame_done only with the 4th pixel; a 5th pixel lands at (10,5).
- CASET 0,20,0,10 (start>end) -> win_err pulses once; a following RAMWR starts at the previous XS.
- cs raised after 5 bits of a byte, then a full byte 0x2A -> one byte_valid with data 0x2A only.
- RAMWR, single byte 0xAB, then command 0x2B -> no pix_valid; FSM ends in RASET_P.
- lcd_rst pulsed low during a RAMWR stream -> window returns to 0..239 and the FSM to IDLE; subsequent data bytes yield no pixels until the next 0x2C.
